// File: rtl/backend_stall_ctrl_if.sv
// rtl/backend_stall_ctrl_if.sv - backend stall/flush sequencer signal bundle
//
// Purpose: groups the event inputs and stall/control outputs of
//          backend_stall_ctrl. When STALL_PERF_EN is defined the bundle
//          also carries the 32-bit performance counters.
// Modports:
//   master : pipeline side; drives the event inputs, observes stall controls
//   slave  : backend_stall_ctrl; consumes events, drives stall controls
// Signals:
//   ex_div_req, div_done, ex_dc_miss, dc_data_ok, wb_flush_csr, mem_br,
//   wb_idle, intr_pending                    (master -> slave)
//   stall_ex, stall_ex_buf, stall_dcache, stall_dcache_buf, stall_front,
//   div_cancel, idle_wake, hang              (slave -> master)
//   perf_div_stall, perf_dc_stall, perf_idle_cyc (STALL_PERF_EN only)
interface backend_stall_ctrl_if;
  logic ex_div_req;
  logic div_done;
  logic ex_dc_miss;
  logic dc_data_ok;
  logic wb_flush_csr;
  logic mem_br;
  logic wb_idle;
  logic intr_pending;
  logic stall_ex;
  logic stall_ex_buf;
  logic stall_dcache;
  logic stall_dcache_buf;
  logic stall_front;
  logic div_cancel;
  logic idle_wake;
  logic hang;
`ifdef STALL_PERF_EN
  logic [31:0] perf_div_stall;
  logic [31:0] perf_dc_stall;
  logic [31:0] perf_idle_cyc;
`endif

  modport master (
    output ex_div_req, div_done, ex_dc_miss, dc_data_ok,
           wb_flush_csr, mem_br, wb_idle, intr_pending,
    input  stall_ex, stall_ex_buf, stall_dcache, stall_dcache_buf,
           stall_front, div_cancel, idle_wake, hang
`ifdef STALL_PERF_EN
    , input perf_div_stall, perf_dc_stall, perf_idle_cyc
`endif
  );

  modport slave (
    input  ex_div_req, div_done, ex_dc_miss, dc_data_ok,
           wb_flush_csr, mem_br, wb_idle, intr_pending,
    output stall_ex, stall_ex_buf, stall_dcache, stall_dcache_buf,
           stall_front, div_cancel, idle_wake, hang
`ifdef STALL_PERF_EN
    , output perf_div_stall, perf_dc_stall, perf_idle_cyc
`endif
  );
endinterface

// File: rtl/backend_stall_ctrl.sv
// rtl/backend_stall_ctrl.sv - central stall/flush sequencer for the EX->MEM->WB backend
//
// Purpose: generates divider and dcache stalls (plus one-cycle delayed _buf
//          copies), arbitrates them against CSR flush and MEM branch redirect,
//          sequences the IDLE instruction and runs a hang watchdog.
// Ports:
//   clk  : clock
//   rstn : synchronous active-low reset
//   bus  : backend_stall_ctrl_if.slave (event inputs, stall/control outputs)
// Parameters:
//   TIMEOUT : wait cycles per outstanding event before hang is flagged
//   CNT_W   : watchdog counter width, 2^CNT_W > TIMEOUT
// Optional feature: STALL_PERF_EN adds perf_div_stall / perf_dc_stall /
//   perf_idle_cyc cycle counters on the bus.
module backend_stall_ctrl #(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  backend_stall_ctrl_if.slave   bus
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic             div_busy;
  logic             dc_busy;
  logic [0:0]       state;
  logic [CNT_W-1:0] wd_cnt;
  logic             hang_r;
  logic             stall_ex_q;
  logic             stall_dc_q;

  logic div_start, div_wait, div_kill, stall_ex_c;
  logic dc_start, dc_wait, dc_kill, stall_dc_c;
  logic in_idle;

  // A new wait only starts when no wait is outstanding; the done pulse of an
  // outstanding wait releases the pipeline in the same cycle.
  assign div_start = bus.ex_div_req & ~div_busy & ~bus.div_done;
  assign div_wait  = div_start | (div_busy & ~bus.div_done);
  assign dc_start  = bus.ex_dc_miss & ~dc_busy;
  assign dc_wait   = dc_start | (dc_busy & ~bus.dc_data_ok);

  // A MEM branch only kills a wait that has not started yet (younger insn);
  // an outstanding wait belongs to an older instruction and survives.
  assign div_kill = bus.wb_flush_csr | (bus.mem_br & ~div_busy);
  assign dc_kill  = bus.wb_flush_csr | (bus.mem_br & ~dc_busy);

  // Combinational outputs are gated by rstn so everything reads 0 in reset.
  assign stall_ex_c = rstn & div_wait & ~div_kill;
  assign stall_dc_c = rstn & dc_wait & ~dc_kill;
  assign in_idle    = (state == ST_IDLE);

  assign bus.stall_ex         = stall_ex_c;
  assign bus.stall_dcache     = stall_dc_c;
  assign bus.stall_ex_buf     = stall_ex_q;
  assign bus.stall_dcache_buf = stall_dc_q;
  assign bus.stall_front      = in_idle;
  assign bus.div_cancel       = rstn & bus.wb_flush_csr & (div_busy | bus.ex_div_req);
  assign bus.idle_wake        = rstn & in_idle & bus.intr_pending & ~bus.wb_flush_csr;
  assign bus.hang             = rstn & (hang_r | (wd_cnt == TIMEOUT_C));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_busy   <= 1'b0;
      dc_busy    <= 1'b0;
      state      <= ST_RUN;
      wd_cnt     <= '0;
      hang_r     <= 1'b0;
      stall_ex_q <= 1'b0;
      stall_dc_q <= 1'b0;
    end else begin
      stall_ex_q <= stall_ex_c;
      stall_dc_q <= stall_dc_c;

      if (bus.wb_flush_csr) begin
        div_busy <= 1'b0;
      end else if (div_busy) begin
        if (bus.div_done) div_busy <= 1'b0;
      end else if (div_start & ~bus.mem_br) begin
        div_busy <= 1'b1;
      end

      if (bus.wb_flush_csr) begin
        dc_busy <= 1'b0;
      end else if (dc_busy) begin
        if (bus.dc_data_ok) dc_busy <= 1'b0;
      end else if (dc_start & ~bus.mem_br) begin
        dc_busy <= 1'b1;
      end

      if (div_busy | dc_busy) begin
        if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      if (wd_cnt == TIMEOUT_C) hang_r <= 1'b1;

      case (state)
        ST_RUN:  if (bus.wb_idle & ~bus.wb_flush_csr) state <= ST_IDLE;
        ST_IDLE: if (bus.wb_flush_csr | bus.intr_pending) state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_div_q;
  logic [31:0] perf_dc_q;
  logic [31:0] perf_idle_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_div_q  <= '0;
      perf_dc_q   <= '0;
      perf_idle_q <= '0;
    end else begin
      if (stall_ex_c) perf_div_q  <= perf_div_q + 32'd1;
      if (stall_dc_c) perf_dc_q   <= perf_dc_q + 32'd1;
      if (in_idle)    perf_idle_q <= perf_idle_q + 32'd1;
    end
  end

  assign bus.perf_div_stall = perf_div_q;
  assign bus.perf_dc_stall  = perf_dc_q;
  assign bus.perf_idle_cyc  = perf_idle_q;
`endif

endmodule

// File: tb/tb_backend_stall_ctrl.sv
// tb/tb_backend_stall_ctrl.sv - scoreboard testbench for backend_stall_ctrl
module tb_backend_stall_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  backend_stall_ctrl_if m ();
  backend_stall_ctrl_if w ();

  backend_stall_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (m.slave)
  );

  backend_stall_ctrl #(.TIMEOUT(8), .CNT_W(10)) dut_wd (
    .clk  (clk),
    .rstn (rstn),
    .bus  (w.slave)
  );

  // output vector order: se, seb, sd, sdb, sf, dc, iw, hg
  logic [7:0] main_out, wd_out;
  assign main_out = {m.stall_ex, m.stall_ex_buf, m.stall_dcache, m.stall_dcache_buf,
                     m.stall_front, m.div_cancel, m.idle_wake, m.hang};
  assign wd_out   = {w.stall_ex, w.stall_ex_buf, w.stall_dcache, w.stall_dcache_buf,
                     w.stall_front, w.div_cancel, w.idle_wake, w.hang};

  typedef struct {
    bit         wd;
    logic [7:0] exp;
    logic [7:0] msk;
    string      nm;
    int         k;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [7:0] ov(bit se, bit seb, bit sd, bit sdb,
                                    bit sf, bit dc, bit iw, bit hg);
    return {se, seb, sd, sdb, sf, dc, iw, hg};
  endfunction

  // input vector order: req, done, miss, ok, flush, br, idle, intr
  function automatic logic [7:0] iv(bit req, bit done, bit miss, bit ok,
                                    bit fl, bit br, bit idl, bit intr);
    return {req, done, miss, ok, fl, br, idl, intr};
  endfunction

  task automatic drive_main(input logic [7:0] in);
    {m.ex_div_req, m.div_done, m.ex_dc_miss, m.dc_data_ok,
     m.wb_flush_csr, m.mem_br, m.wb_idle, m.intr_pending} = in;
  endtask

  task automatic drive_wd(input logic [7:0] in);
    {w.ex_div_req, w.div_done, w.ex_dc_miss, w.dc_data_ok,
     w.wb_flush_csr, w.mem_br, w.wb_idle, w.intr_pending} = in;
  endtask

  // One clock cycle: drive inputs just after the edge and queue the
  // expected outputs for that cycle.
  task automatic cyc(input bit wd, input bit rs, input logic [7:0] in,
                     input logic [7:0] exp, input logic [7:0] msk,
                     input string nm, input int k);
    exp_t e;
    @(posedge clk);
    #1;
    rstn = rs;
    if (wd) begin
      drive_wd(in);
      drive_main(8'h00);
    end else begin
      drive_main(in);
      drive_wd(8'h00);
    end
    e.wd = wd; e.exp = exp; e.msk = msk; e.nm = nm; e.k = k;
    q.push_back(e);
  endtask

  task automatic run(input logic [7:0] in, input logic [7:0] exp,
                     input string nm, input int k);
    cyc(1'b0, 1'b1, in, exp, 8'hFF, nm, k);
  endtask

  // Monitor: compares every queued expectation at the falling edge.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = e.wd ? wd_out : main_out;
        n_chk++;
        if ((act & e.msk) !== (e.exp & e.msk)) begin
          n_fail++;
          $display("FAIL %s[%0d]: got %b expected %b (mask %b)",
                   e.nm, e.k, act, e.exp, e.msk);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    drive_main(8'hFF);
    drive_wd(8'hFF);

    // reset with all inputs high
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, "reset_main", k);
    end
    cyc(1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, "reset_wd", 0);
    run(8'h00, 8'h00, "post_reset", 0);
    run(8'h00, 8'h00, "post_reset", 1);

    // divider wait, done at cycle 17
    for (int k = 0; k <= 17; k++) begin
      run(iv(1, k == 17, 0, 0, 0, 0, 0, 0),
          ov(k <= 16, k >= 1, 0, 0, 0, 0, 0, 0), "div_wait", k);
    end
    run(8'h00, 8'h00, "div_after", 18);

    // concurrent divider and dcache miss
    for (int k = 0; k <= 12; k++) begin
      run(iv(1, k == 12, k <= 5, k == 5, 0, 0, 0, 0),
          ov(k <= 11, k >= 1, k <= 4, (k >= 1) && (k <= 5), 0, 0, 0, 0),
          "div_and_miss", k);
    end
    run(8'h00, 8'h00, "div_and_miss_after", 13);

    // flush mid divider wait, then a stray div_done
    for (int k = 0; k <= 4; k++) begin
      run(iv(1, 0, 0, 0, k == 4, 0, 0, 0),
          ov(k <= 3, (k >= 1) && (k <= 4), 0, 0, 0, k == 4, 0, 0), "flush_div", k);
    end
    for (int k = 5; k <= 8; k++) begin
      run(iv(0, k == 7, 0, 0, 0, 0, 0, 0), 8'h00, "stray_done", k);
    end

    // mem_br kills only not-yet-started waits
    run(iv(1, 0, 1, 0, 0, 1, 0, 0), 8'h00, "br_young", 0);
    run(8'h00, 8'h00, "br_young", 1);
    run(iv(1, 0, 0, 0, 0, 0, 0, 0), ov(1, 0, 0, 0, 0, 0, 0, 0), "br_old", 2);
    run(iv(1, 0, 0, 0, 0, 1, 0, 0), ov(1, 1, 0, 0, 0, 0, 0, 0), "br_old", 3);
    run(iv(1, 1, 0, 0, 0, 0, 0, 0), ov(0, 1, 0, 0, 0, 0, 0, 0), "br_old", 4);
    run(8'h00, 8'h00, "br_old", 5);

    // IDLE entry and interrupt wake-up
    run(iv(0, 0, 0, 0, 0, 0, 1, 0), 8'h00, "idle", 0);
    for (int k = 1; k <= 30; k++) begin
      run(iv(0, 0, 0, 0, 0, 0, 0, k == 30),
          ov(0, 0, 0, 0, 1, 0, k == 30, 0), "idle", k);
    end
    run(8'h00, 8'h00, "idle", 31);

    // flush while idle leaves without idle_wake
    run(iv(0, 0, 0, 0, 0, 0, 1, 0), 8'h00, "idle_flush", 0);
    run(8'h00, ov(0, 0, 0, 0, 1, 0, 0, 0), "idle_flush", 1);
    run(iv(0, 0, 0, 0, 1, 0, 0, 1), ov(0, 0, 0, 0, 1, 0, 0, 0), "idle_flush", 2);
    run(8'h00, 8'h00, "idle_flush", 3);

    // IDLE retiring under flush does not enter IDLE
    run(iv(0, 0, 0, 0, 1, 0, 1, 0), 8'h00, "idle_blocked", 0);
    run(8'h00, 8'h00, "idle_blocked", 1);

    // watchdog with TIMEOUT=8 on the second instance
    for (int k = 0; k <= 12; k++) begin
      cyc(1'b1, 1'b1, iv(0, 0, 1, k == 12, 0, 0, 0, 0),
          ov(0, 0, k <= 11, 0, 0, 0, 0, k >= 9), 8'b0010_0001, "watchdog", k);
    end
    for (int k = 13; k <= 15; k++) begin
      cyc(1'b1, 1'b1, 8'h00, ov(0, 0, 0, 0, 0, 0, 0, 1), 8'b0010_0001,
          "watchdog_sticky", k);
    end
    run(8'h00, 8'h00, "main_no_hang", 0);

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
